// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// The HALT state exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam logic [31:0] RV_NOP = 32'h00000013;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} fetch_state_e;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_e;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; clear empties it and overrides push/pop.
// Storage is reset so the head reads as zero out of reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fetch_entry_t  push_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, responses buffered with their PC.
// Optional misaligned-PC trap (NOP entry + HALT) under FETCH_MISALIGN_CHECK_EN.
//
//   state | meaning
//   IDLE  | one cycle after reset
//   REQ   | presenting the PC to imem while there is FIFO room
//   WAIT  | request accepted, waiting for the response
//   DRAIN | flushed while waiting; swallow the orphaned response
//   HALT  | misaligned PC trapped; idle until flush
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_req_pc;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_room;
  logic          w_hs;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;

  assign w_room        = (w_count < CW'(DEPTH));
  assign w_hs          = imem_req_valid & imem_req_ready;
  assign pc_stall      = ~w_hs;
  assign imem_req_addr = word_align(pc_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) r_req_pc <= pc_in;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    w_push         = 1'b0;
    w_push_data    = '{pc: r_req_pc, instr: imem_rsp_data, misaligned: 1'b0};
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (!flush && w_room) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc_in[1:0] != 2'b00) begin
            w_push      = 1'b1;
            w_push_data = '{pc: pc_in, instr: NOP_INSTR, misaligned: 1'b1};
            w_state_nxt = HALT;
          end else
`endif
          begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          w_push      = ~flush;
          w_state_nxt = REQ;
        end else if (flush) begin
          w_state_nxt = DRAIN;
        end
      end
      // The response seen here belongs to the pre-flush request, so it is always dropped.
      DRAIN: begin
        if (imem_rsp_valid) w_state_nxt = REQ;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      HALT: begin
        if (flush) w_state_nxt = REQ;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push & ~w_full),
    .pop       (out_valid & out_ready),
    .clear     (flush),
    .push_data (w_push_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  assign out_valid = ~w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign out_misaligned = w_head.misaligned;
`else
  assign out_misaligned = 1'b0;
`endif

endmodule
